fir_mac_scheduler: RTL and testbench

Time-multiplexed FIR engine. One shared 16x16 multiply-accumulate unit serves NUM_CH independent audio channels, for example the L/R high-pass and L/R low-pass paths at 48 kHz. A round-robin scheduler grants one pending channel sample at a time and runs NUM_COEF serial MAC cycles against that channel's circular delay line and coefficient bank. The result is returned through a valid/ready output. It replaces per-channel fully parallel FIR instances between the synth voice mixer and the I2S/DAC output stage.

---
 rtl/fir_sched_pkg.sv | 42 ++++
 rtl/fir_mac_scheduler_rr_arbiter.sv | 39 +++
 rtl/fir_mac_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sched_pkg
//  Purpose  : Shared types, constants and the output saturation helper for
//             the time-multiplexed FIR MAC scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_sched_pkg;

    // Accumulator is sized for the largest supported tap count so that a full
    // pass over 64 worst-case products cannot overflow.
    localparam int c_MAX_COEF = 64;
    localparam int c_ACC_W    = 32 + $clog2(c_MAX_COEF);

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef shortint                    sample_t;
    typedef shortint                    coef_t;
    typedef logic signed [c_ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Arithmetic floor shift followed by a clamp to the signed 16-bit range.
    function automatic sample_t sat16(input acc_t a, input int shift);
        acc_t s;
        s = a >>> shift;
        if (s > acc_t'(SAT_MAX)) begin
            return sample_t'(SAT_MAX);
        end
        if (s < acc_t'(SAT_MIN)) begin
            return sample_t'(SAT_MIN);
        end
        return sample_t'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Grants the lowest-numbered
//             requester at or after ptr, wrapping around N.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Scan upward from ptr and grant the first requester encountered.
    always_comb begin
        logic w_found;
        int   w_c;
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int i = 0; i < N; i++) begin
            w_c = (int'(ptr) + i) % N;
            if (!w_found && req[w_c]) begin
                w_found  = 1'b1;
                gnt[w_c] = 1'b1;
                idx      = IW'(w_c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_scheduler
//  Purpose  : One shared 16x16 MAC time-multiplexed over NUM_CH FIR channels.
//             Round-robin sample acceptance, NUM_COEF serial taps per sample,
//             saturated result returned over a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int NUM_COEF = 33,
    parameter int SHIFT    = 15
)(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CH-1:0]                             in_valid,
    input  logic [NUM_CH-1:0][15:0]                       in_sample,
    output logic [NUM_CH-1:0]                             in_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic signed [15:0]                            out_sample,
    input  logic                                          cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [$clog2(NUM_COEF)-1:0]                   cfg_addr,
    input  logic signed [15:0]                            cfg_data,
    output logic                                          cfg_ack,
    output logic                                          busy
);

    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_CO_W = $clog2(NUM_COEF);
    localparam int c_K_W  = $clog2(NUM_COEF + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    sample_t             r_dl   [NUM_CH][NUM_COEF];
    coef_t               r_coef [NUM_CH][NUM_COEF];
    logic [c_CO_W-1:0]   r_wp   [NUM_CH];
    logic [c_CH_W-1:0]   r_rr;
    logic [c_CH_W-1:0]   r_ch;
    logic [c_K_W-1:0]    r_k;
    acc_t                r_acc;
    logic signed [31:0]  r_prod;
    sample_t             r_out_sample;
    logic                r_cfg_ack;

    logic [NUM_CH-1:0]   w_gnt;
    logic [c_CH_W-1:0]   w_gnt_idx;
    logic                w_hs;
    logic                w_last;
    logic                w_cfg_ok;
    logic [c_CO_W-1:0]   w_tap;
    logic signed [31:0]  w_prod;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (c_CH_W)
    ) u_arb (
        .req (in_valid),
        .ptr (r_rr),
        .gnt (w_gnt),
        .idx (w_gnt_idx)
    );

    assign w_hs       = (r_state == IDLE) && (|in_valid);
    assign w_last     = (32'(r_k) == NUM_COEF);
    assign w_cfg_ok   = cfg_we && (r_state == IDLE) && !w_hs &&
                        (32'(cfg_ch) < NUM_CH) && (32'(cfg_addr) < NUM_COEF);

    assign in_ready   = (r_state == IDLE) ? w_gnt : '0;
    assign busy       = (r_state != IDLE);
    assign out_valid  = (r_state == OUT);
    assign out_ch     = r_ch;
    assign out_sample = r_out_sample;
    assign cfg_ack    = r_cfg_ack;

    // Circular tap address (wp - k) mod NUM_COEF and the registered-MAC product.
    always_comb begin
        int w_t;
        w_t = int'(r_wp[r_ch]) - int'(r_k);
        if (w_t < 0) begin
            w_t = w_t + NUM_COEF;
        end
        w_tap  = c_CO_W'(w_t);
        w_prod = int'(r_coef[r_ch][c_CO_W'(r_k)]) * int'(r_dl[r_ch][w_tap]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept a sample, run the taps, hold the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs)      w_state_nxt = MAC;
            MAC:     if (w_last)    w_state_nxt = OUT;
            OUT:     if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Datapath: delay lines, coefficient banks, pointers and the accumulator.
    // The product is registered one cycle before accumulation, so the final
    // tap is folded in on the extra cycle where k == NUM_COEF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wp[c] <= '0;
                for (int t = 0; t < NUM_COEF; t++) begin
                    r_dl[c][t]   <= '0;
                    r_coef[c][t] <= '0;
                end
            end
            r_rr         <= '0;
            r_ch         <= '0;
            r_k          <= '0;
            r_acc        <= '0;
            r_prod       <= '0;
            r_out_sample <= '0;
            r_cfg_ack    <= 1'b0;
        end else begin
            r_cfg_ack <= w_cfg_ok;
            if (w_cfg_ok) begin
                r_coef[cfg_ch][cfg_addr] <= coef_t'(cfg_data);
            end
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_dl[w_gnt_idx][r_wp[w_gnt_idx]] <= sample_t'(in_sample[w_gnt_idx]);
                        r_ch   <= w_gnt_idx;
                        r_acc  <= '0;
                        r_prod <= '0;
                        r_k    <= '0;
                        r_rr   <= (32'(w_gnt_idx) == NUM_CH - 1) ? '0 : w_gnt_idx + 1'b1;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + acc_t'(r_prod);
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_out_sample <= sat16(r_acc + acc_t'(r_prod), SHIFT);
                        r_wp[r_ch]   <= (32'(r_wp[r_ch]) == NUM_COEF - 1) ? '0 : r_wp[r_ch] + 1'b1;
                    end else begin
                        r_prod <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_scheduler
//  Purpose  : Directed, self-checking bench for fir_mac_scheduler
//             (NUM_CH=4, NUM_COEF=33, SHIFT=15).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_scheduler;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          in_valid;
    logic [3:0][15:0]    in_sample;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_ch;
    logic signed [15:0]  out_sample;
    logic                cfg_we;
    logic [1:0]          cfg_ch;
    logic [5:0]          cfg_addr;
    logic signed [15:0]  cfg_data;
    logic                cfg_ack;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int ch;
        int smp;
        int exp;
    } vec_t;

    vec_t tbl [10];

    fir_mac_scheduler #(
        .NUM_CH   (4),
        .NUM_COEF (33),
        .SHIFT    (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_sample (out_sample),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ack    (cfg_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_addr = 6'(addr);
        cfg_data = 16'(data);
        tick();
        check($sformatf("cfg_ack_c%0d_a%0d", ch, addr), cfg_ack, 1);
        cfg_we = 1'b0;
        tick();
    endtask

    task automatic run_sample(input int ch, input int val,
                              output logic signed [15:0] res,
                              output logic [1:0] rch, output int lat);
        int n;
        in_sample[ch] = 16'(val);
        in_valid[ch]  = 1'b1;
        #1;
        n = 0;
        while (!in_ready[ch] && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid[ch] = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        res = out_sample;
        rch = out_ch;
        tick();
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        logic signed [15:0] res;
        logic [1:0]         rch;
        int                 lat;
        int                 n;
        int                 acks;
        int                 exp_order [5];
        logic               ok;

        tbl[0] = '{0, 1000, 500};
        tbl[1] = '{1, 1000, 0};
        tbl[2] = '{1, 0, 0};
        tbl[3] = '{1, 0, 500};
        tbl[4] = '{0, -2000, -1000};
        tbl[5] = '{0, 3, 1};
        tbl[6] = '{0, -3, -2};
        tbl[7] = '{1, 7, 0};
        tbl[8] = '{1, 0, 0};
        tbl[9] = '{1, 0, 3};
        exp_order = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        in_valid  = '0;
        in_sample = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (3) tick();

        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Impulse / delay-tap table
        cfg_write(0, 0, 16384);
        cfg_write(1, 2, 16384);
        for (int i = 0; i < 10; i++) begin
            run_sample(tbl[i].ch, tbl[i].smp, res, rch, lat);
            check($sformatf("vec%0d_latency", i), lat, 34);
            check($sformatf("vec%0d_out_ch", i), rch, tbl[i].ch);
            check($sformatf("vec%0d_out_sample", i), res, tbl[i].exp);
        end

        // Saturation on ch2
        for (int a = 0; a < 33; a++) cfg_write(2, a, 32767);
        for (int i = 0; i < 33; i++) begin
            run_sample(2, 32767, res, rch, lat);
            if (i == 0) check("sat_first_pos", res, 32766);
        end
        check("sat_pos_last", res, 32767);
        for (int i = 0; i < 33; i++) run_sample(2, -32768, res, rch, lat);
        check("sat_neg_last", res, -32768);

        // Coefficient writes are ignored while busy
        in_sample[3] = 16'd1000;
        in_valid[3]  = 1'b1;
        #1;
        n = 0;
        while (!in_ready[3] && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid[3] = 1'b0;
        cfg_we   = 1'b1;
        cfg_ch   = 2'd3;
        cfg_addr = 6'd0;
        cfg_data = 16'sd16384;
        acks = 0;
        repeat (10) begin
            tick();
            if (cfg_ack) acks++;
        end
        check("cfg_busy_state", busy, 1);
        check("cfg_busy_no_ack", acks, 0);
        cfg_we = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("cfg_busy_out_valid", out_valid, 1);
        check("cfg_busy_coef_unchanged", out_sample, 0);
        tick();

        cfg_write(3, 0, 16384);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd3;
        cfg_addr = 6'd40;
        cfg_data = 16'sd100;
        tick();
        check("cfg_bad_addr_ack0", cfg_ack, 0);
        tick();
        check("cfg_bad_addr_ack1", cfg_ack, 0);
        cfg_we = 1'b0;
        tick();
        run_sample(3, 1000, res, rch, lat);
        check("cfg_new_coef_used", res, 500);

        // Round-robin with all channels requesting, then backpressure
        in_sample[0] = 16'd600;
        in_sample[1] = 16'd20;
        in_sample[2] = 16'd30;
        in_sample[3] = 16'd40;
        in_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (in_ready == 4'd0 && n < 200) begin
                tick();
                n++;
            end
            check($sformatf("rr_onehot%0d", g), $onehot(in_ready), 1);
            check($sformatf("rr_grant%0d", g), oh_idx(in_ready), exp_order[g]);
            tick();
            if (g == 4) out_ready = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        check("bp_out_ch", out_ch, 0);
        check("bp_out_sample", out_sample, 300);
        for (int c = 0; c < 10; c++) begin
            tick();
            ok = out_valid && (out_ch == 2'd0) && (out_sample == 16'sd300) && (in_ready == 4'd0);
            check($sformatf("bp_hold_cyc%0d", c), ok, 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_out_released", out_valid, 0);
        check("bp_next_grant_ch1", in_ready, 4'b0010);
        in_valid = '0;
        #1;
        tick();

        // Reset in the middle of a MAC pass
        in_sample[0] = 16'd1000;
        in_valid[0]  = 1'b1;
        #1;
        n = 0;
        while (!in_ready[0] && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid[0] = 1'b0;
        repeat (10) tick();
        check("mid_busy_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_sample", out_sample, 0);
        tick();
        tick();
        rst = 1'b0;
        acks = 0;
        repeat (40) begin
            tick();
            if (out_valid) acks++;
        end
        check("mid_rst_no_output", acks, 0);
        run_sample(0, 1000, res, rch, lat);
        check("post_rst_latency", lat, 34);
        check("post_rst_coef_cleared", res, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
